membus_arbiter: RTL and testbench
=================================

Name: membus_arbiter

Overview:
- Shares one single-ported word memory between crabcore's instruction-fetch port (m0, read-only) and its load/store port (m1, read/write).
- Sits between the core and the memory model/RAM.
- Serialises requests, holds each transaction until the memory acknowledges, and returns a one-cycle ready pulse with read data to the granted requester.
- A watchdog aborts transactions the memory never acknowledges.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 64, cycles to wait for mem_ack before abort; 0 disables the watchdog

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_addr_valid  in  1  fetch request
- m0_addr  in  ADDR_W  fetch address
- m0_ready  out  1  one-cycle completion pulse to fetch
- m0_rdata  out  DATA_W  fetch data, valid while m0_ready
- m1_addr_valid  in  1  load/store request
- m1_addr  in  ADDR_W  load/store address
- m1_data_valid  in  1  request is a write (sampled with m1_addr_valid)
- m1_data  in  DATA_W  write data
- m1_ready  out  1  one-cycle completion pulse to load/store
- m1_rdata  out  DATA_W  load data, valid while m1_ready
- bus_err  out  1  one-cycle pulse, coincident with ready, on watchdog abort
- mem_req  out  1  memory request, level, held until ack
- mem_we  out  1  write enable, stable while mem_req
- mem_addr  out  ADDR_W  memory address, stable while mem_req
- mem_wdata  out  DATA_W  memory write data, stable while mem_req
- mem_ack  in  1  memory completion, single cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- All outputs are registered.
- On reset low, asynchronously:
  - state=IDLE
  - all ready, err and mem_* outputs 0
  - rdata 0
  - last-grant=m0
  - watchdog counter 0
- FSM IDLE:
  - If m1_addr_valid, grant m1; else if m0_addr_valid, grant m0 (fixed priority, m1 first).
  - On grant, latch addr, wdata and we (we = m1_data_valid for m1, 0 for m0).
  - Next cycle: mem_req=1; go to BUSY.
- FSM BUSY:
  - mem_req and the latched fields are held.
  - The watchdog counts from 0.
  - mem_ack seen: drop mem_req; capture mem_rdata (0 for writes); go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: drop mem_req; rdata=0; set err flag; go to RESP.
  - A mem_ack arriving outside BUSY is ignored.
- FSM RESP:
  - The granted port's ready=1 for exactly one cycle, with its rdata; bus_err=err flag.
  - The non-granted ready stays 0.
  - Then return to IDLE; rdata outputs return to 0.
- Latency: request sampled in cycle 0 → mem_req in cycle 1 → ack in cycle k≥1 → ready in cycle k+1.
  - Minimum request-to-ready is 2 cycles.
  - One idle bubble before the next grant (RESP→IDLE).
- Requester rules:
  - Hold valid, addr and data stable until ready.
  - A valid that drops mid-transaction does not cancel it; ready is still pulsed.
  - A valid still high in the ready cycle is a new request, sampled in the following IDLE.
- Both ports requesting in IDLE: m1 wins; m0 waits and is granted next IDLE if still valid.
- A reset assertion in any state immediately returns to IDLE with mem_req=0; the in-flight transaction is lost.

Optional Feature:
- MEMBUS_RR_EN defined:
  - When both ports request in IDLE, grant the port not granted last (round-robin).
  - A single requester is granted regardless.
  - last-grant updates on every grant.
- Undefined: fixed priority m1 over m0; no last-grant register.

Decomposition:
- Package membus_pkg:
  - state enum typedef (IDLE, BUSY, RESP)
  - grant typedef (GNT_M0, GNT_M1)
  - default width constants
- One sub-module, membus_grant: combinational priority/round-robin selector plus the last-grant register.
  - Inputs: both valids, a grant strobe.
  - Output: the grant.
  - Contains the MEMBUS_RR_EN switch.

Test Plan:
- m0 read at 0x0000_0010, memory returns 0xDEAD_BEEF with ack 3 cycles after mem_req → mem_req high for cycles 1-3, mem_we=0, m0_ready pulses in cycle 4 with m0_rdata=0xDEAD_BEEF, m1_ready stays 0.
- m1 write, addr 0x0000_0100, data 0x1234_5678, immediate ack → mem_we=1, mem_wdata=0x1234_5678, m1_ready one cycle, m1_rdata=0, memory word 0x40 updated.
- m0 and m1 valid together, held high for 4 transactions → grants m1,m1,m1,m1 (fixed); with MEMBUS_RR_EN → m1,m0,m1,m0.
- TIMEOUT=8, memory never acks m0 read → mem_req drops after 8 cycles; m0_ready and bus_err pulse together; m0_rdata=0; next request serviced normally.
- reset driven low two cycles into BUSY, mid-clock → mem_req falls without a clock edge; no ready pulse; after release a new m1 read completes correctly.
- Stray mem_ack in IDLE, and m0_addr_valid dropped during BUSY → no spurious ready; the dropped request still completes with one m0_ready.

Source files
------------

// File: rtl/membus_pkg.sv
// Shared types and default sizes for the crabcore memory-bus arbiter.
// Holds the FSM state encoding and the grant encoding used by all membus files.
// No logic here; pure declarations.
package membus_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } grant_t;

endpackage

// File: rtl/membus_grant.sv
// Requester selector: picks m0 or m1 from the two request valids.
// Latency: combinational grant; the last-grant register updates on the grant strobe.
// Backpressure: none; the caller only strobes when it actually accepts a request.
// Optional MEMBUS_RR_EN: round-robin on contention instead of fixed m1-first priority.
module membus_grant
    import membus_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   m0_valid,
    input  logic   m1_valid,
    input  logic   grant_stb,
    output grant_t grant
);

`ifdef MEMBUS_RR_EN
    grant_t last_grant;

    // On a tie, serve whichever port was not served last; a lone requester always wins.
    always_comb begin
        grant = GNT_M0;
        if (m0_valid && m1_valid) begin
            grant = (last_grant == GNT_M0) ? GNT_M1 : GNT_M0;
        end else if (m1_valid) begin
            grant = GNT_M1;
        end
    end

    // Remember who was granted so the next tie goes the other way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GNT_M0;
        end else if (grant_stb) begin
            last_grant <= grant;
        end
    end
`else
    // Fixed priority: load/store always beats fetch.
    always_comb begin
        grant = m1_valid ? GNT_M1 : GNT_M0;
    end

    // Clock, reset and strobe only matter for the round-robin build.
    logic unused_ok;
    assign unused_ok = ^{clk, reset, grant_stb};
`endif

endmodule

// File: rtl/membus_arbiter.sv
// Shares one single-ported word memory between fetch (m0) and load/store (m1).
// Latency: request sampled in cycle 0, mem_req from cycle 1, ready one cycle after mem_ack.
// Backpressure: one transaction at a time; requesters hold valid until their ready pulse.
// Optional MEMBUS_RR_EN selects round-robin arbitration inside membus_grant.
module membus_arbiter
    import membus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_addr_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_addr_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_data_valid,
    input  logic [DATA_W-1:0] m1_data,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Watchdog width covers 0..TIMEOUT-1; TIMEOUT of 0 turns the abort off entirely.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state;
    grant_t            grant_sel;
    grant_t            grant_q;
    logic [CNT_W-1:0]  wd_cnt;
    logic              wd_expired;
    logic              any_req;
    logic              grant_stb;
    logic              txn_done;
    logic [DATA_W-1:0] resp_data;

    assign any_req    = m0_addr_valid | m1_addr_valid;
    assign grant_stb  = (state == IDLE) && any_req;
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign txn_done   = mem_ack || wd_expired;

    membus_grant u_grant (
        .clk       (clk),
        .reset     (reset),
        .m0_valid  (m0_addr_valid),
        .m1_valid  (m1_addr_valid),
        .grant_stb (grant_stb),
        .grant     (grant_sel)
    );

    // Read data returned to the requester: memory data for acked reads, zero for writes and aborts.
    always_comb begin
        resp_data = '0;
        if (mem_ack && !mem_we) begin
            resp_data = mem_rdata;
        end
    end

    // Transaction FSM: grant in IDLE, hold the memory request in BUSY, pulse ready in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant_q   <= GNT_M0;
            wd_cnt    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_sel;
                        wd_cnt  <= '0;
                        mem_req <= 1'b1;
                        state   <= BUSY;
                        if (grant_sel == GNT_M1) begin
                            mem_addr  <= m1_addr;
                            mem_we    <= m1_data_valid;
                            mem_wdata <= m1_data;
                        end else begin
                            mem_addr  <= m0_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (txn_done) begin
                        // An ack in the same cycle as expiry still counts as a success.
                        mem_req <= 1'b0;
                        bus_err <= !mem_ack;
                        state   <= RESP;
                        if (grant_q == GNT_M1) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= resp_data;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= resp_data;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    m0_rdata <= '0;
                    m1_rdata <= '0;
                    bus_err  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter with a small word-memory model.
// Memory acks after a programmable number of mem_req cycles (0 = never).
// Build with MEMBUS_RR_EN defined to expect round-robin grant order.
module tb_membus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_addr_valid;
    logic [AW-1:0] m0_addr;
    logic          m0_ready;
    logic [DW-1:0] m0_rdata;
    logic          m1_addr_valid;
    logic [AW-1:0] m1_addr;
    logic          m1_data_valid;
    logic [DW-1:0] m1_data;
    logic          m1_ready;
    logic [DW-1:0] m1_rdata;
    logic          bus_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata = '0;

    logic          model_ack = 1'b0;
    logic          stray_ack = 1'b0;
    int            ack_lat   = 1;
    int            req_cyc   = 0;
    logic [31:0]   mem_arr [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    membus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .m0_addr_valid (m0_addr_valid),
        .m0_addr       (m0_addr),
        .m0_ready      (m0_ready),
        .m0_rdata      (m0_rdata),
        .m1_addr_valid (m1_addr_valid),
        .m1_addr       (m1_addr),
        .m1_data_valid (m1_data_valid),
        .m1_data       (m1_data),
        .m1_ready      (m1_ready),
        .m1_rdata      (m1_rdata),
        .bus_err       (bus_err),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    assign mem_ack = model_ack | stray_ack;

    // Memory model: acks in the ack_lat-th cycle of mem_req; write data shows a junk read value.
    always @(negedge clk) begin
        if (mem_req) begin
            req_cyc = req_cyc + 1;
            if (ack_lat != 0 && req_cyc == ack_lat) begin
                model_ack = 1'b1;
                if (mem_we) begin
                    mem_arr[mem_addr[9:2]] = mem_wdata;
                    mem_rdata = 32'hA5A5_A5A5;
                end else begin
                    mem_rdata = mem_arr[mem_addr[9:2]];
                end
            end else begin
                model_ack = 1'b0;
            end
        end else begin
            req_cyc   = 0;
            model_ack = 1'b0;
            mem_rdata = 32'h0BAD_0BAD;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until either ready pulses; port = 0/1/2(both) or -1 when the budget runs out.
    task automatic wait_ready(output int port, input int limit);
        port = -1;
        for (int i = 0; i < limit && port == -1; i++) begin
            tick();
            if (m0_ready && m1_ready) port = 2;
            else if (m1_ready)        port = 1;
            else if (m0_ready)        port = 0;
        end
    endtask

    initial begin
        int p;
        int n0;
        int n1;
        logic [31:0] seen;
        int exp_g [4];
`ifdef MEMBUS_RR_EN
        exp_g = '{1, 0, 1, 0};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[4] = 32'hDEAD_BEEF;
        mem_arr[8] = 32'h1111_2222;
        reset = 1'b0;
        m0_addr_valid = 1'b0; m0_addr = '0;
        m1_addr_valid = 1'b0; m1_addr = '0;
        m1_data_valid = 1'b0; m1_data = '0;

        // Reset state
        repeat (2) tick();
        check("rst_mem_req",  mem_req,  1'b0);
        check("rst_mem_we",   mem_we,   1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_m0_ready", m0_ready, 1'b0);
        check("rst_m1_ready", m1_ready, 1'b0);
        check("rst_bus_err",  bus_err,  1'b0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        reset = 1'b1;
        tick();

        // m0 read, ack in the third mem_req cycle
        ack_lat = 3;
        m0_addr = 32'h0000_0010;
        m0_addr_valid = 1'b1;
        tick();
        check("t1_req_c1",  mem_req,  1'b1);
        check("t1_we_c1",   mem_we,   1'b0);
        check("t1_addr_c1", mem_addr, 32'h0000_0010);
        tick();
        check("t1_req_c2",  mem_req,  1'b1);
        tick();
        check("t1_req_c3",  mem_req,  1'b1);
        check("t1_rdy_c3",  m0_ready, 1'b0);
        tick();
        check("t1_rdy_c4",   m0_ready, 1'b1);
        check("t1_rdata_c4", m0_rdata, 32'hDEAD_BEEF);
        check("t1_m1rdy_c4", m1_ready, 1'b0);
        check("t1_req_c4",   mem_req,  1'b0);
        m0_addr_valid = 1'b0;
        tick();
        check("t1_rdy_c5",   m0_ready, 1'b0);
        check("t1_rdata_c5", m0_rdata, 32'h0);

        // m1 write, immediate ack
        ack_lat = 1;
        m1_addr = 32'h0000_0100;
        m1_data = 32'h1234_5678;
        m1_data_valid = 1'b1;
        m1_addr_valid = 1'b1;
        tick();
        check("t2_req",   mem_req,   1'b1);
        check("t2_we",    mem_we,    1'b1);
        check("t2_wdata", mem_wdata, 32'h1234_5678);
        check("t2_addr",  mem_addr,  32'h0000_0100);
        tick();
        check("t2_rdy",    m1_ready, 1'b1);
        check("t2_rdata",  m1_rdata, 32'h0);
        check("t2_m0rdy",  m0_ready, 1'b0);
        m1_addr_valid = 1'b0;
        m1_data_valid = 1'b0;
        tick();
        check("t2_rdy_off", m1_ready, 1'b0);
        check("t2_memword", mem_arr[64], 32'h1234_5678);

        // Both requesting for four transactions, starting from a fresh last-grant
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        ack_lat = 1;
        m0_addr = 32'h0000_0010;
        m1_addr = 32'h0000_0020;
        m1_data_valid = 1'b0;
        m0_addr_valid = 1'b1;
        m1_addr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(p, 20);
            check("t3_grant", 32'(p), 32'(exp_g[k]));
            check("t3_rdata", m0_rdata | m1_rdata,
                  (exp_g[k] == 1) ? 32'h1111_2222 : 32'hDEAD_BEEF);
        end
        m0_addr_valid = 1'b0;
        m1_addr_valid = 1'b0;
        tick();
        check("t3_quiet", {30'h0, m0_ready, m1_ready}, 32'h0);

        // Watchdog abort on an m0 read that is never acked
        ack_lat = 0;
        m0_addr = 32'h0000_0010;
        m0_addr_valid = 1'b1;
        tick();
        check("t4_req_c1", mem_req, 1'b1);
        repeat (7) tick();
        check("t4_req_c8", mem_req,  1'b1);
        check("t4_rdy_c8", m0_ready, 1'b0);
        tick();
        check("t4_req_c9",   mem_req,  1'b0);
        check("t4_rdy_c9",   m0_ready, 1'b1);
        check("t4_err_c9",   bus_err,  1'b1);
        check("t4_rdata_c9", m0_rdata, 32'h0);
        m0_addr_valid = 1'b0;
        tick();
        check("t4_err_c10", bus_err,  1'b0);
        check("t4_rdy_c10", m0_ready, 1'b0);
        ack_lat = 2;
        m0_addr_valid = 1'b1;
        wait_ready(p, 20);
        check("t4_next_port",  32'(p),   32'h0);
        check("t4_next_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("t4_next_err",   bus_err,  1'b0);
        m0_addr_valid = 1'b0;
        tick();

        // Asynchronous reset two cycles into BUSY
        ack_lat = 0;
        m1_addr = 32'h0000_0020;
        m1_data_valid = 1'b0;
        m1_addr_valid = 1'b1;
        tick();
        tick();
        check("t5_req_pre", mem_req, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check("t5_req_async", mem_req, 1'b0);
        m1_addr_valid = 1'b0;
        n1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (m1_ready || m0_ready) n1++;
        end
        check("t5_no_ready", 32'(n1), 32'h0);
        reset = 1'b1;
        tick();
        ack_lat = 2;
        m1_addr_valid = 1'b1;
        wait_ready(p, 20);
        check("t5_after_port",  32'(p),   32'h1);
        check("t5_after_rdata", m1_rdata, 32'h1111_2222);
        m1_addr_valid = 1'b0;
        tick();

        // Stray ack while idle, then an m0 read whose valid drops during BUSY
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        check("t6_stray_rdy", {30'h0, m0_ready, m1_ready}, 32'h0);
        check("t6_stray_req", mem_req, 1'b0);
        tick();
        check("t6_stray_rdy2", {30'h0, m0_ready, m1_ready}, 32'h0);
        ack_lat = 3;
        m0_addr = 32'h0000_0010;
        m0_addr_valid = 1'b1;
        tick();
        tick();
        m0_addr_valid = 1'b0;
        n0 = 0;
        n1 = 0;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m0_ready) begin
                n0++;
                seen = m0_rdata;
            end
            if (m1_ready) n1++;
        end
        check("t6_m0_pulses", 32'(n0), 32'h1);
        check("t6_m1_pulses", 32'(n1), 32'h0);
        check("t6_rdata",     seen,    32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
